// File: rtl/sfifo_wr_arb.sv
// -----------------------------------------------------------------------------
// sfifo_wr_arb
//
// Round-robin write arbiter sharing the single write port of a synchronous
// FIFO among NUM_REQ producers. One producer is granted per cycle. The granted
// word is registered onto wren/wdata/grant_id one cycle after the handshake.
// The full/pre_full flags are used so that wren is never asserted into a full
// FIFO.
//
// Handshake: producer i transfers a word in a cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge. req_ready is combinational,
// at most one bit is set, and a producer must hold req_data stable while
// valid and not yet granted. Dropping req_valid before a grant is harmless.
//
// Optional feature (macro SFIFO_WR_ARB_PKT_LOCK_EN):
//   adds req_last; a transfer with req_last[k]=0 locks arbitration to k
//   until a transfer from k with req_last[k]=1 (or srst).
//
// Ports:
//   clk        clock, rising edge
//   srst       synchronous reset, active-high
//   req_valid  per-producer valid
//   req_data   producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last   (feature only) per-producer end-of-packet marker
//   req_ready  per-producer grant, combinational, one-hot or zero
//   wren       FIFO write enable, registered
//   wdata      FIFO write data, registered
//   grant_id   producer index of the word on wdata, registered
//   pre_full   FIFO has exactly one free slot
//   full       FIFO has no free slot
// -----------------------------------------------------------------------------
module sfifo_wr_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wren,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    input  logic                          pre_full,
    input  logic                          full
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       rr_ptr_nxt;
    logic [NUM_REQ-1:0]    cand;
    logic                  can_grant;
    logic                  grant_found;
    logic [ID_W-1:0]       grant_k;
    logic [ID_W-1:0]       grant_k_inc;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  xfer;
    logic                  advance;

    // The (pre_full && wren) term covers the write already on the port,
    // which is about to take the last free slot. A concurrent read is not
    // counted as credit.
    assign can_grant = !full && !(pre_full && wren) && !srst;

`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
    typedef enum logic {LOCK_IDLE = 1'b0, LOCK_HELD = 1'b1} lock_state_t;

    lock_state_t     lock_state, lock_state_nxt;
    logic [ID_W-1:0] lock_id, lock_id_nxt;
    logic [NUM_REQ-1:0] lock_mask;

    // While a packet is in progress only the locked producer is a candidate.
    always_comb begin
        lock_mask = '0;
        lock_mask[lock_id] = 1'b1;
        cand = (lock_state == LOCK_HELD) ? (req_valid & lock_mask) : req_valid;
    end

    always_comb begin
        lock_state_nxt = lock_state;
        lock_id_nxt    = lock_id;
        advance        = xfer;
        if (xfer) begin
            lock_id_nxt = grant_k;
            if (req_last[grant_k]) begin
                lock_state_nxt = LOCK_IDLE;
            end else begin
                lock_state_nxt = LOCK_HELD;
                advance        = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lock_state <= LOCK_IDLE;
            lock_id    <= '0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_id    <= lock_id_nxt;
        end
    end
`else
    assign cand    = req_valid;
    assign advance = xfer;
`endif

    // Search candidates starting at rr_ptr, ascending, wrapping at NUM_REQ.
    always_comb begin
        int idx;
        logic [ID_W-1:0] idx_v;
        idx         = 0;
        idx_v       = '0;
        grant_found = 1'b0;
        grant_k     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = ID_W'(idx);
            if (!grant_found && cand[idx_v]) begin
                grant_found = 1'b1;
                grant_k     = idx_v;
            end
        end
    end

    assign grant_data  = req_data[int'(grant_k)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer        = can_grant && grant_found;
    assign grant_k_inc = (grant_k == LAST_IDX) ? '0 : grant_k + 1'b1;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant_k] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (advance) begin
            rr_ptr_nxt = grant_k_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wren     <= 1'b0;
            wdata    <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            wren   <= xfer;
            rr_ptr <= rr_ptr_nxt;
            if (xfer) begin
                wdata    <= grant_data;
                grant_id <= grant_k;
            end
        end
    end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
module tb_sfifo_wr_arb;

  localparam int DW   = 32;
  localparam int NR   = 4;
  localparam int ID_W = $clog2(NR);
  localparam int W    = ID_W + DW;

  logic               clk;
  logic               srst;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
  logic [NR-1:0]      req_last;
`endif
  logic [NR-1:0]      req_ready;
  logic               wren;
  logic [DW-1:0]      wdata;
  logic [ID_W-1:0]    grant_id;
  logic               pre_full;
  logic               full;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  sfifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk       (clk),
    .srst      (srst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
    .req_last  (req_last),
`endif
    .req_ready (req_ready),
    .wren      (wren),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .pre_full  (pre_full),
    .full      (full)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: set inputs for the coming cycle, fresh random data each time
  task automatic drive(input logic rst, input logic [NR-1:0] v, input logic pf, input logic f);
    srst      = rst;
    req_valid = v;
    pre_full  = pf;
    full      = f;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom();
  endtask

  // one cycle: check grant mid-cycle, push expected write, check port after edge
  task automatic run_cycle(input string tag, input logic [NR-1:0] exp_ready);
    logic [W-1:0] e;
    int k;
    @(negedge clk);
    check_val({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
    if (exp_ready != '0) begin
      k = 0;
      for (int i = 0; i < NR; i++) if (exp_ready[i]) k = i;
      exp_q.push_back({ID_W'(k), req_data[k*DW +: DW]});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_wren"}, 64'(wren), 64'(1));
      check_val({tag, "_wdata"}, 64'(wdata), 64'(e[DW-1:0]));
      check_val({tag, "_gid"}, 64'(grant_id), 64'(e[W-1:DW]));
    end else begin
      check_val({tag, "_wren"}, 64'(wren), 64'(0));
    end
  endtask

  initial begin
    logic [NR-1:0] rr_exp[8];
    checks = 0;
    errors = 0;
`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
    req_last = '1;
`endif

    // reset with all producers valid
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    run_cycle("rst0", 4'b0000);
    run_cycle("rst1", 4'b0000);
    check_val("rst_wdata", 64'(wdata), 64'(0));
    check_val("rst_gid", 64'(grant_id), 64'(0));

    // round-robin, all valid
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1111, 1'b0, 1'b0);
      run_cycle("rr", rr_exp[i]);
    end

    // move pointer to 2, then sparse 1/3
    drive(1'b0, 4'b0010, 1'b0, 1'b0);
    run_cycle("sp_pre", 4'b0010);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1010, 1'b0, 1'b0);
      run_cycle("sparse", (i % 2 == 0) ? 4'b1000 : 4'b0010);
    end

    // near full: pointer at 2
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    run_cycle("nf_a", 4'b0100);
    drive(1'b0, 4'b1111, 1'b1, 1'b0);
    run_cycle("nf_blk", 4'b0000);
    drive(1'b0, 4'b1111, 1'b1, 1'b0);
    run_cycle("nf_one", 4'b1000);
    drive(1'b0, 4'b1111, 1'b1, 1'b0);
    run_cycle("nf_blk2", 4'b0000);
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    run_cycle("nf_b", 4'b0001);

    // full for 5 cycles, pointer held at 1
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1111, (i % 2 == 0), 1'b1);
      run_cycle("full", 4'b0000);
    end
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    run_cycle("full_res", 4'b0010);

    // reset mid-operation drops the in-flight word
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    run_cycle("mid_a", 4'b0100);
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    run_cycle("mid_rst", 4'b0000);
    drive(1'b0, 4'b1111, 1'b0, 1'b0);
    run_cycle("mid_post", 4'b0001);

    // single requester granted every cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1000, 1'b0, 1'b0);
      run_cycle("single", 4'b1000);
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0);
    run_cycle("idle", 4'b0000);

`ifdef SFIFO_WR_ARB_PKT_LOCK_EN
    // pointer at 0: producer 2 sends a 3-word packet
    drive(1'b0, 4'b0100, 1'b0, 1'b0);
    req_last = 4'b0000;
    run_cycle("pk0", 4'b0100);
    drive(1'b0, 4'b0111, 1'b0, 1'b0);
    req_last = 4'b0000;
    run_cycle("pk1", 4'b0100);
    drive(1'b0, 4'b0111, 1'b0, 1'b0);
    req_last = 4'b0100;
    run_cycle("pk2", 4'b0100);
    drive(1'b0, 4'b0111, 1'b0, 1'b0);
    req_last = 4'b1111;
    run_cycle("pk_next", 4'b0001);
    // pointer at 1: lock to 1, then reset clears it
    drive(1'b0, 4'b0010, 1'b0, 1'b0);
    req_last = 4'b0000;
    run_cycle("pk_l1", 4'b0010);
    drive(1'b1, 4'b0111, 1'b0, 1'b0);
    run_cycle("pk_rst", 4'b0000);
    drive(1'b0, 4'b0101, 1'b0, 1'b0);
    req_last = 4'b1111;
    run_cycle("pk_free", 4'b0001);
`endif

    if (exp_q.size() != 0) check_val("q_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
